// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and types for the 1-to-4 stream demux.
//   N_CH   - number of output channels
//   W_DEF  - default payload width
//   CNT_W  - width of the optional per-channel accept counters
//   ch_idx_t - channel index type
package demux_pkg;
  localparam int N_CH  = 4;
  localparam int W_DEF = 4;
  localparam int CNT_W = 8;
  typedef logic [1:0] ch_idx_t;
endpackage

// File: rtl/stream_slot.sv
// stream_slot: one-entry valid/data holding register for a single channel.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load, din - write din and set valid (wins over pop)
//   pop       - consumer took the item; clears valid unless load
//   valid, data - registered contents
module stream_slot #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      // a load on the same edge as a pop replaces the item with no bubble
      valid <= 1'b1;
      data  <= din;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1_4_stream.sv
// demux_1_4_stream: routes a valid/ready stream to one of four channels,
// each buffered by a one-entry register (one cycle of latency).
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_data/in_sel/in_ready - upstream handshake, in_sel picks channel
//   out_valid[k], out_dataK, out_ready[k] - per-channel downstream handshake
//   cnt0..cnt3          - accepted-item counters (only with DEMUX_1_4_STREAM_COUNT_EN)
// Build option: define DEMUX_1_4_STREAM_COUNT_EN to add the counters.
module demux_1_4_stream
  import demux_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [W-1:0]    in_data,
  input  ch_idx_t         in_sel,
  output logic            in_ready,
  output logic [N_CH-1:0] out_valid,
  output logic [W-1:0]    out_data0,
  output logic [W-1:0]    out_data1,
  output logic [W-1:0]    out_data2,
  output logic [W-1:0]    out_data3,
`ifdef DEMUX_1_4_STREAM_COUNT_EN
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3,
`endif
  input  logic [N_CH-1:0] out_ready
);

  logic                     accept;
  logic [N_CH-1:0]          load;
  logic [N_CH-1:0]          pop;
  logic [N_CH-1:0][W-1:0]   data_q;

  // Ready only looks at the addressed slot: free, or draining this edge.
  assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign load[k] = accept & (in_sel == ch_idx_t'(k));
    assign pop[k]  = out_valid[k] & out_ready[k];

    stream_slot #(.W(W)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[k]),
      .pop   (pop[k]),
      .din   (in_data),
      .valid (out_valid[k]),
      .data  (data_q[k])
    );
  end

  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];

`ifdef DEMUX_1_4_STREAM_COUNT_EN
  logic [N_CH-1:0][CNT_W-1:0] cnt_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_cnt
    // natural wrap at 2**CNT_W
    always_ff @(posedge clk) begin
      if (rst)          cnt_q[k] <= '0;
      else if (load[k]) cnt_q[k] <= cnt_q[k] + 1'b1;
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux_1_4_stream.sv
module tb_demux_1_4_stream;
  import demux_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  ch_idx_t      in_sel;
  logic         in_ready;
  logic [3:0]   out_valid;
  logic [W-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0]   out_ready;
`ifdef DEMUX_1_4_STREAM_COUNT_EN
  logic [7:0]   cnt0, cnt1, cnt2, cnt3;
`endif

  always #5 clk = ~clk;

  demux_1_4_stream #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
`ifdef DEMUX_1_4_STREAM_COUNT_EN
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .cnt3      (cnt3),
`endif
    .out_ready (out_ready)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel is a one-item mailbox; a slot accepts when it is
  // empty or being emptied this cycle; reset empties everything.
  bit       mv  [4];
  int       md  [4];
  int       mc  [4];
  bit       started = 0;

  function automatic bit model_ready(input int s);
    return !mv[s] || out_ready[s];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin mv[k] = 0; md[k] = 0; mc[k] = 0; end
      started = 1;
    end else if (started) begin
      int  s;
      bit  take;
      s    = int'(in_sel);
      take = in_valid && model_ready(s);
      for (int k = 0; k < 4; k++) begin
        if (take && k == s) begin
          mv[k] = 1; md[k] = int'(in_data); mc[k] = (mc[k] + 1) % 256;
        end else if (mv[k] && out_ready[k]) begin
          mv[k] = 0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      int dd [4];
      dd[0] = int'(out_data0); dd[1] = int'(out_data1);
      dd[2] = int'(out_data2); dd[3] = int'(out_data3);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("model valid%0d", k), int'(out_valid[k]), int'(mv[k]));
        if (mv[k]) chk($sformatf("model data%0d", k), dd[k], md[k]);
      end
      chk("model in_ready", int'(in_ready), int'(model_ready(int'(in_sel))));
`ifdef DEMUX_1_4_STREAM_COUNT_EN
      chk("model cnt0", int'(cnt0), mc[0]);
      chk("model cnt1", int'(cnt1), mc[1]);
      chk("model cnt2", int'(cnt2), mc[2]);
      chk("model cnt3", int'(cnt3), mc[3]);
`endif
    end
  end

  // Apply inputs, sample in_ready before the edge, then settle after it.
  task automatic drive(input bit v, input int d, input int s, output bit ir);
    in_valid = v;
    in_data  = W'(d);
    in_sel   = ch_idx_t'(s);
    #1;
    ir = in_ready;
    @(posedge clk);
    #1;
  endtask

  bit ir;

  initial begin
    rst = 1; in_valid = 0; in_data = 0; in_sel = 0; out_ready = 4'hf;
    drive(0, 0, 0, ir);
    drive(0, 0, 0, ir);
    rst = 0;
    #1;
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset data0", int'(out_data0), 0);
    chk("reset data3", int'(out_data3), 0);
    chk("reset in_ready", int'(in_ready), 1);

    // basic routing
    drive(1, 'ha, 0, ir);
    chk("route0 valid", int'(out_valid), 'b0001);
    chk("route0 data", int'(out_data0), 'ha);
    drive(1, 'hb, 1, ir);
    chk("route1 valid", int'(out_valid), 'b0010);
    chk("route1 data", int'(out_data1), 'hb);
    drive(1, 'hc, 2, ir);
    chk("route2 valid", int'(out_valid), 'b0100);
    chk("route2 data", int'(out_data2), 'hc);
    drive(1, 'hd, 3, ir);
    chk("route3 valid", int'(out_valid), 'b1000);
    chk("route3 data", int'(out_data3), 'hd);
    drive(0, 0, 0, ir);
    chk("route drained", int'(out_valid), 0);

    // backpressure on channel 2
    out_ready = 4'b1011;
    drive(1, 7, 2, ir);
    chk("bp first ready", int'(ir), 1);
    chk("bp data2 first", int'(out_data2), 7);
    drive(1, 3, 2, ir);
    chk("bp second ready", int'(ir), 0);
    chk("bp data2 held", int'(out_data2), 7);
    chk("bp valid2 held", int'(out_valid[2]), 1);
    out_ready = 4'hf;
    drive(1, 3, 2, ir);
    chk("bp retry ready", int'(ir), 1);
    chk("bp data2 new", int'(out_data2), 3);
    drive(0, 0, 0, ir);

    // same-channel back-to-back
    drive(1, 1, 1, ir);
    chk("ovl ready a", int'(ir), 1);
    chk("ovl data a", int'(out_data1), 1);
    drive(1, 2, 1, ir);
    chk("ovl ready b", int'(ir), 1);
    chk("ovl data b", int'(out_data1), 2);
    drive(1, 3, 1, ir);
    chk("ovl ready c", int'(ir), 1);
    chk("ovl data c", int'(out_data1), 3);
    chk("ovl valid", int'(out_valid), 'b0010);
    drive(0, 0, 0, ir);

    // blocked channel 0 vs free channel 3
    out_ready = 4'h0;
    drive(1, 5, 0, ir);
    drive(1, 10, 3, ir);
    chk("free ch3 ready", int'(ir), 1);
    chk("free ch3 data", int'(out_data3), 10);
    chk("free valid", int'(out_valid), 'b1001);

    // mid-operation reset with all four full and an item in flight
    drive(1, 6, 1, ir);
    drive(1, 8, 2, ir);
    chk("full valid", int'(out_valid), 'hf);
    rst = 1;
    drive(1, 9, 1, ir);
    rst = 0;
    in_valid = 0;
    #1;
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst data1", int'(out_data1), 0);
    chk("rst in_ready", int'(in_ready), 1);

`ifdef DEMUX_1_4_STREAM_COUNT_EN
    out_ready = 4'hf;
    for (int i = 0; i < 255; i++) drive(1, i % 16, 0, ir);
    chk("cnt0 at 255", int'(cnt0), 255);
    drive(1, 0, 0, ir);
    chk("cnt0 wrap", int'(cnt0), 0);
    chk("cnt1", int'(cnt1), 0);
    chk("cnt2", int'(cnt2), 0);
    chk("cnt3", int'(cnt3), 0);
`endif

    drive(0, 0, 0, ir);
    drive(0, 0, 0, ir);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
